// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: parity encodings,
// transmitter FSM states and the baud divisor helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Clocks per line bit; integer division, the remainder is dropped.
    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data. Pointers carry one extra
// bit so that full and empty can be told apart when the indices match.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign rdata   = mem[rd_ptr_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer update; wraps naturally through the extra MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage array holds data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: FIFO-buffered words are serialised as
// start, LSB-first data, optional parity and one or two stop bits, with
// queued frames sent back-to-back.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int BAUD_DIV = baud_div(CLK_FREQ_HZ, BAUD_RATE);
    localparam int CNT_W    = $clog2(BAUD_DIV);
    localparam int BIT_W    = $clog2(DATA_BITS);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be in 5..9");
    end
    if (BAUD_DIV < 2) begin : g_bad_baud_div
        $error("uart_tx_frame: BAUD_DIV must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_frame: FIFO_DEPTH must be a power of 2, at least 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    // Parity of a word as it will appear on the line.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        return (PARITY == PARITY_ODD) ? ~^d : ^d;
    endfunction

    tx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       baud_q;
    logic [BIT_W-1:0]       bit_q;
    logic                   stop_q;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;
    logic                   bit_end;
    logic                   last_data;
    logic                   last_stop;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_BITS-1:0]   fifo_rdata;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_valid && tx_ready),
        .wdata (tx_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign tx_ready  = !fifo_full;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;
    assign tx        = tx_q;
    assign bit_end   = (baud_q == CNT_W'(BAUD_DIV - 1));
    assign last_data = (bit_q == BIT_W'(DATA_BITS - 1));
    assign last_stop = (stop_q == 1'(STOP_BITS - 1));

    // Next state and FIFO pop; the last stop-bit cycle chains directly
    // into the next start bit when a word is waiting.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && last_data)
                    state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end && last_stop) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shift register and parity follow the pop; tx is precomputed from the
    // next state so the registered line changes on the same edge.
    always_comb begin
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = 1'b1;
        if (pop) begin
            shift_d = fifo_rdata;
            par_d   = parity_bit(fifo_rdata);
        end else if (state_q == ST_DATA && bit_end) begin
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
        end
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    // Control state: FSM, baud counter, bit indices and the line register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            if (state_q == ST_IDLE || bit_end) baud_q <= '0;
            else                               baud_q <= baud_q + CNT_W'(1);
            if (state_q == ST_DATA && bit_end)
                bit_q <= last_data ? '0 : bit_q + BIT_W'(1);
            if (state_q == ST_STOP && bit_end)
                stop_q <= last_stop ? 1'b0 : stop_q + 1'b1;
        end
    end

    // Frame data path registers carry no reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter and successor to the fixed 8N1 transmitter. Configurable data width, parity and stop bits, with a baud divisor derived from clock frequency and baud rate. A synchronous transmit FIFO decouples the producer from line timing, and queued frames go out back-to-back with no idle gap. It sits between the SoC bus-side UART register block and the `tx` pad.

## Interface
Parameters:
- `CLK_FREQ_HZ`, 50_000_000: input clock frequency.
- `BAUD_RATE`, 115200: line rate. `BAUD_DIV = CLK_FREQ_HZ / BAUD_RATE` uses integer division and must be ≥ 2.
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: transmit FIFO entries; power of 2, ≥ 2.

Ports:
- `clk` input 1: single clock for the whole block.
- `rst_n` input 1: asynchronous, active-low reset.
- `tx_data` input `DATA_BITS`: word to queue.
- `tx_valid` input 1: producer offers `tx_data`.
- `tx_ready` output 1: FIFO not full. A write is accepted on a rising edge where `tx_valid && tx_ready`.
- `tx` output 1: serial line, idle high.
- `busy` output 1: the FSM is not IDLE, or the FIFO is non-empty.
- `fifo_level` output `$clog2(FIFO_DEPTH)+1`: number of stored entries.

## Operation
- Reset values (applied asynchronously while `rst_n` = 0): `tx`=1, `tx_ready`=1, `busy`=0, `fifo_level`=0, FSM in IDLE. FIFO pointers and all counters are cleared.
- Frame format:
  - One start bit (0).
  - `DATA_BITS` data bits, LSB first.
  - A parity bit if `PARITY` ≠ 0: even = XOR of the data bits, odd = inverted XOR.
  - `STOP_BITS` stop bits (1).
- FSM states: IDLE → START → DATA → PARITY (skipped when `PARITY` = 0) → STOP.
  - STOP → START if the FIFO is non-empty at the last cycle of the final stop bit; that cycle also performs the pop.
  - STOP → IDLE otherwise.
- IDLE with the FIFO non-empty: pop the head into the shift register and go to START.
- Baud counter:
  - Counts 0..`BAUD_DIV`-1; each line bit is held for exactly `BAUD_DIV` clocks.
  - The counter clears on every state entry from IDLE.
  - The bit index counts data bits 0..`DATA_BITS`-1 and the stop-bit index counts 0..`STOP_BITS`-1.
- FIFO:
  - A write and a pop in the same cycle leave `fifo_level` unchanged; the data order is preserved.
  - A write while full cannot occur (`tx_ready`=0) and the FIFO is unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`; full/empty are distinguished by the extra pointer bit.
- Reset mid-frame: `tx` returns to 1 immediately, the FIFO is flushed, and the partial frame is abandoned. After release, the first accepted write starts a clean frame.
- `tx_data` and `tx_valid` are don't-care when there is no handshake.

## Timing
- Write accepted at edge 0 into an empty FIFO while IDLE:
  - `fifo_level`=1 and `busy`=1 after edge 0.
  - Pop at edge 1.
  - `tx` falls after edge 1, i.e. 2 clocks of latency from `tx_valid` being sampled.
- Frame length: `BAUD_DIV` × (1 + `DATA_BITS` + (`PARITY`≠0) + `STOP_BITS`) clocks.
- Back-to-back frames: the next start bit begins on the clock immediately after the final stop bit; there are no extra idle cycles.
- `tx_ready` drops in the cycle after the write that fills the FIFO. It rises in the cycle after the next pop.
- `tx` is driven from a register; there is no combinational path from inputs to `tx`.

## Structure
- Shared package `uart_pkg`:
  - Parity encodings `PARITY_NONE`=0, `PARITY_EVEN`=1, `PARITY_ODD`=2.
  - The FSM state encoding.
  - A baud-divisor function `baud_div(clk_hz, baud)`.
- Sub-module `sync_fifo` (parameters `WIDTH`, `DEPTH`): push/pop, `full`, `empty`, `level`, same `clk`/`rst_n`.
- Elaboration checks reject `DATA_BITS` outside 5..9, `BAUD_DIV` < 2, and `FIFO_DEPTH` that is not a power of 2.

## Test plan
All scenarios use `CLK_FREQ_HZ`=1_000_000 and `BAUD_RATE`=100_000, giving `BAUD_DIV`=10.
- Reset: hold `rst_n`=0 for 5 clocks → `tx`=1, `tx_ready`=1, `busy`=0, `fifo_level`=0. Assert `rst_n`=0 asynchronously mid-cycle → outputs change before the next edge.
- 8N1 write of 0xA5 at edge 0 → `tx` low for edges 2..11, then bits 1,0,1,0,0,1,0,1 for 10 clocks each, then stop high for 10 clocks. `busy` drops 102 clocks after the write.
- Parity and stop bits:
  - `PARITY`=1, data 0x07 → parity bit 1.
  - `PARITY`=2, data 0x07 → parity bit 0.
  - `STOP_BITS`=2 → line high for 20 clocks before `busy` drops.
- FIFO full, `FIFO_DEPTH`=4: hold `tx_valid`=1 with data 0x01..0x06 → 0x01 is popped immediately and 0x02..0x05 are stored. `tx_ready`=0 and `fifo_level`=4 while 0x06 is pending. 0x06 is accepted after the 0x02 pop, and all frames go out back-to-back with no gap.
- Reset during data bit 3 of 0x3C with 2 entries queued → `tx`=1 immediately and `fifo_level`=0. After release, a write of 0x55 produces a correct single frame.
- `DATA_BITS`=5, `PARITY`=1, data 0x1B → start, 1,1,0,1,1, parity 0, stop. The frame lasts 80 clocks.
